// File: rtl/uart_io_scheduler.sv
// CPU <-> UART byte scheduler: a TX FIFO drained by a send FSM, plus a show-ahead RX FIFO.
// The polled status bits come only from registered counts, so CPU strobes never reach them combinationally.

module uart_io_scheduler_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    head,
  output logic [AW:0]   count
);
  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         wrPtr, rdPtr;

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rdPtr];
endmodule

module uart_io_scheduler #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CpuEn,
  input  logic          TxWrite,
  input  logic [7:0]    TxData,
  input  logic          RxRead,
  output logic [7:0]    RxData,
  output logic          TxSpace,
  output logic          RxAvail,
  output logic          TxBusy,
  output logic [AW:0]   TxCount,
  output logic [AW:0]   RxCount,
  input  logic          ErrClear,
  output logic          TxOverflow,
  output logic          RxOverflow,
  output logic          UartTxValid,
  output logic [7:0]    UartTxData,
  input  logic          UartTxReady,
  input  logic          UartRxValid,
  input  logic [7:0]    UartRxData,
  output logic          UartRxReady
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SEND} txState_t;
  txState_t state;

  logic       txFull, txEmpty, rxFull, rxEmpty;
  logic       txPush, txPop, rxPush, rxPop;
  logic       txOvSet, rxOvSet;
  logic [7:0] txHead, rxHead;

  assign txFull  = (TxCount == FULL_CNT);
  assign txEmpty = (TxCount == '0);
  assign rxFull  = (RxCount == FULL_CNT);
  assign rxEmpty = (RxCount == '0);

  // Full is judged on the registered count, so a same-cycle pop never makes room for a push.
  assign txPush  = TxWrite & CpuEn & !txFull;
  assign txOvSet = TxWrite & CpuEn & txFull;
  assign txPop   = !txEmpty & ((state == IDLE) | UartTxReady);

  assign UartRxReady = !rxFull;
  assign rxPush  = UartRxValid & UartRxReady;
  assign rxOvSet = UartRxValid & !UartRxReady;
  assign rxPop   = RxRead & CpuEn & !rxEmpty;

  uart_io_scheduler_fifo #(.DEPTH(DEPTH), .AW(AW)) uTxFifo (
    .clk(clk), .rst_n(rst_n), .push(txPush), .pop(txPop),
    .din(TxData), .head(txHead), .count(TxCount)
  );

  uart_io_scheduler_fifo #(.DEPTH(DEPTH), .AW(AW)) uRxFifo (
    .clk(clk), .rst_n(rst_n), .push(rxPush), .pop(rxPop),
    .din(UartRxData), .head(rxHead), .count(RxCount)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      UartTxValid <= 1'b0;
      UartTxData  <= 8'h00;
    end else begin
      unique case (state)
        IDLE: if (!txEmpty) begin
          UartTxData  <= txHead;
          UartTxValid <= 1'b1;
          state       <= SEND;
        end
        SEND: if (UartTxReady) begin
          if (!txEmpty) UartTxData <= txHead;
          else begin
            UartTxValid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A set condition beats ErrClear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TxOverflow <= 1'b0;
      RxOverflow <= 1'b0;
    end else begin
      TxOverflow <= txOvSet | (TxOverflow & !ErrClear);
      RxOverflow <= rxOvSet | (RxOverflow & !ErrClear);
    end
  end

  assign TxSpace = !txFull;
  assign RxAvail = !rxEmpty;
  assign TxBusy  = (state == SEND) | !txEmpty;
  assign RxData  = rxEmpty ? 8'h00 : rxHead;
endmodule
